// File: rtl/lc_request_loader_if.sv
// Host write port and lifecycle-request outputs of lc_request_loader.
// The host drives the write strobe side; the loader drives the identifiers and status.
interface lc_request_loader_if;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [255:0] lc_transition_id;
    logic         lc_transition_request_in;
    logic [255:0] lc_authentication_id;
    logic         lc_authentication_valid;
    logic         busy;
    logic         loaded;
    logic         err;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  lc_transition_id, lc_transition_request_in, lc_authentication_id,
        input  lc_authentication_valid, busy, loaded, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output lc_transition_id, lc_transition_request_in, lc_authentication_id,
        output lc_authentication_valid, busy, loaded, err
    );
endinterface

// File: rtl/lc_request_loader.sv
// Collects 8 transition-id and 8 authentication-id words from the host, then on a
// go command issues one request pulse with authentication_valid held for HOLD_CYCLES.
module lc_request_loader #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    lc_request_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t       state;
    logic [15:0]  mask;
    logic [255:0] trans_id;
    logic [255:0] auth_id;
    logic [7:0]   cnt;
    logic         req_q;
    logic         valid_q;
    logic         busy_q;
    logic         err_q;

    logic         loaded;
    logic         word_wr;
    logic         go;
    logic         set_err;
    logic         clr_err;

    always_comb begin
        loaded  = &mask;
        word_wr = bus.wr_en && (bus.wr_addr[4] == 1'b0);
        go      = bus.wr_en && (bus.wr_addr == 5'd16) && bus.wr_data[0];
        clr_err = bus.wr_en && (bus.wr_addr == 5'd17);
        set_err = 1'b0;
        if (state == IDLE)
            set_err = go && !loaded;
        else
            set_err = bus.wr_en && (bus.wr_addr <= 5'd16);
    end

    // The counter starts at HOLD_CYCLES-1 in the REQ cycle itself, so REQ plus HOLD
    // together span exactly HOLD_CYCLES cycles; HOLD_CYCLES=1 returns straight to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mask     <= '0;
            trans_id <= '0;
            auth_id  <= '0;
            cnt      <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (word_wr) begin
                        if (bus.wr_addr[3] == 1'b0)
                            trans_id[32*bus.wr_addr[2:0] +: 32] <= bus.wr_data;
                        else
                            auth_id[32*bus.wr_addr[2:0] +: 32] <= bus.wr_data;
                        mask[bus.wr_addr[3:0]] <= 1'b1;
                    end
                    if (go && loaded) begin
                        state   <= REQ;
                        cnt     <= 8'(HOLD_CYCLES - 1);
                        req_q   <= 1'b1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ, HOLD: begin
                    req_q <= 1'b0;
                    if (cnt == 8'd0) begin
                        state   <= IDLE;
                        mask    <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state <= HOLD;
                        cnt   <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (set_err)
                err_q <= 1'b1;
            else if (clr_err)
                err_q <= 1'b0;
        end
    end

    assign bus.lc_transition_id         = trans_id;
    assign bus.lc_authentication_id     = auth_id;
    assign bus.lc_transition_request_in = req_q;
    assign bus.lc_authentication_valid  = valid_q;
    assign bus.busy                     = busy_q;
    assign bus.loaded                   = loaded;
    assign bus.err                      = err_q;
endmodule

// File: tb/tb_lc_request_loader.sv
// Directed bench for lc_request_loader: a default instance (HOLD_CYCLES=16) and a
// HOLD_CYCLES=1 instance receive identical host writes and are checked side by side.
module tb_lc_request_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    lc_request_loader_if bus();
    lc_request_loader_if bus1();

    lc_request_loader dut (.clk(clk), .rst(rst), .bus(bus));
    lc_request_loader #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [4:0] addr, input logic [31:0] data);
        bus.wr_en  = en;  bus.wr_addr  = addr; bus.wr_data  = data;
        bus1.wr_en = en;  bus1.wr_addr = addr; bus1.wr_data = data;
    endtask

    // One host write occupying one clock; returns 1 time unit after the capturing edge.
    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        drive(1'b1, addr, data);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_all(input logic [31:0] base, input int unsigned n_words);
        for (int unsigned n = 0; n < n_words; n++)
            wr(5'(n), base + n);
    endtask

    // Counts request pulses / valid / busy over a fixed 40-cycle window starting now;
    // optionally drives a write of word 3 at iteration inject_at.
    task automatic window(input int inject_at, output int p0, output int v0,
                          output int p1, output int v1, output int b1);
        p0 = 0; v0 = 0; p1 = 0; v1 = 0; b1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.lc_transition_request_in)  p0++;
            if (bus.lc_authentication_valid)   v0++;
            if (bus1.lc_transition_request_in) p1++;
            if (bus1.lc_authentication_valid)  v1++;
            if (bus1.busy)                     b1++;
            if (i == inject_at) drive(1'b1, 5'd3, 32'hDEAD_BEEF);
            else                drive(1'b0, 5'd0, 32'd0);
            @(posedge clk); #1;
        end
        drive(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int p0, v0, p1, v1, b1;
        drive(1'b0, 5'd0, 32'd0);

        // Reset state, observed while rst is still asserted
        rst = 1'b1;
        #2;
        check("rst_valid", 256'(bus.lc_authentication_valid), 256'd0);
        check("rst_busy",  256'(bus.busy), 256'd0);
        check("rst_req",   256'(bus.lc_transition_request_in), 256'd0);
        check("rst_loaded", 256'(bus.loaded), 256'd0);
        check("rst_err",   256'(bus.err), 256'd0);
        check("rst_tid",   bus.lc_transition_id, 256'd0);
        check("rst_aid",   bus.lc_authentication_id, 256'd0);
        do_reset();

        // Full load then go
        load_all(32'h1000_0000, 16);
        check("full_loaded", 256'(bus.loaded), 256'd1);
        wr(5'd16, 32'd0);
        check("go0_busy", 256'(bus.busy), 256'd0);
        check("go0_err",  256'(bus.err), 256'd0);
        wr(5'd20, 32'hFFFF_FFFF);
        check("addr20_err", 256'(bus.err), 256'd0);
        wr(5'd16, 32'd1);
        check("req_pulse", 256'(bus.lc_transition_request_in), 256'd1);
        check("req_busy",  256'(bus.busy), 256'd1);
        check("tid_w0",    256'(bus.lc_transition_id[31:0]), 256'h1000_0000);
        check("aid_w7",    256'(bus.lc_authentication_id[255:224]), 256'h1000_000F);
        window(-1, p0, v0, p1, v1, b1);
        check("pulses",    256'(p0), 256'd1);
        check("valid_len", 256'(v0), 256'd16);
        check("end_busy",  256'(bus.busy), 256'd0);
        check("end_loaded", 256'(bus.loaded), 256'd0);
        check("end_err",   256'(bus.err), 256'd0);
        check("tid_kept",  256'(bus.lc_transition_id[127:96]), 256'h1000_0003);
        check("h1_pulses", 256'(p1), 256'd1);
        check("h1_valid",  256'(v1), 256'd1);
        check("h1_busy",   256'(b1), 256'd1);
        check("h1_loaded", 256'(bus1.loaded), 256'd0);

        // No re-issue without reload: go after completion is an error
        wr(5'd16, 32'd1);
        check("reissue_req", 256'(bus.lc_transition_request_in), 256'd0);
        check("reissue_err", 256'(bus.err), 256'd1);

        // Partial load, go refused, err cleared by addr 17
        do_reset();
        load_all(32'h1000_0000, 15);
        check("partial_loaded", 256'(bus.loaded), 256'd0);
        wr(5'd16, 32'd1);
        window(-1, p0, v0, p1, v1, b1);
        check("partial_pulses", 256'(p0), 256'd0);
        check("partial_err",  256'(bus.err), 256'd1);
        check("partial_busy", 256'(bus.busy), 256'd0);
        wr(5'd17, 32'd0);
        check("err_clear", 256'(bus.err), 256'd0);

        // Write of word 3 during HOLD is ignored and flagged
        do_reset();
        load_all(32'h1000_0000, 16);
        wr(5'd16, 32'd1);
        window(3, p0, v0, p1, v1, b1);
        check("hold_wr_err",   256'(bus.err), 256'd1);
        check("hold_wr_tid",   256'(bus.lc_transition_id[127:96]), 256'h1000_0003);
        check("hold_wr_valid", 256'(v0), 256'd16);
        check("hold_wr_pulse", 256'(p0), 256'd1);

        // Reset in the 5th HOLD cycle
        do_reset();
        load_all(32'h1000_0000, 16);
        wr(5'd16, 32'd1);
        wr(5'd5, 32'h0);            // HOLD cycle 1, sets err
        repeat (4) begin @(posedge clk); #1; end
        check("mid_valid_pre", 256'(bus.lc_authentication_valid), 256'd1);
        check("mid_err_pre",   256'(bus.err), 256'd1);
        rst = 1'b1;
        #1;
        check("mid_valid",  256'(bus.lc_authentication_valid), 256'd0);
        check("mid_busy",   256'(bus.busy), 256'd0);
        check("mid_tid",    bus.lc_transition_id, 256'd0);
        check("mid_aid",    bus.lc_authentication_id, 256'd0);
        check("mid_loaded", 256'(bus.loaded), 256'd0);
        check("mid_err",    256'(bus.err), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        window(-1, p0, v0, p1, v1, b1);
        check("post_rst_pulses", 256'(p0), 256'd0);
        check("post_rst_valid",  256'(v0), 256'd0);

        // Two back-to-back load/go sequences; first write accepted right after release
        do_reset();
        load_all(32'h1000_0000, 16);
        wr(5'd16, 32'd1);
        window(-1, p0, v0, p1, v1, b1);
        check("seq1_pulses", 256'(p0), 256'd1);
        check("seq1_valid",  256'(v0), 256'd16);
        load_all(32'h2000_0000, 16);
        wr(5'd16, 32'd1);
        window(-1, p0, v0, p1, v1, b1);
        check("seq2_pulses", 256'(p0), 256'd1);
        check("seq2_valid",  256'(v0), 256'd16);
        check("seq2_tid_w0", 256'(bus.lc_transition_id[31:0]), 256'h2000_0000);
        check("seq2_tid_w7", 256'(bus.lc_transition_id[255:224]), 256'h2000_0007);
        check("seq2_aid_w0", 256'(bus.lc_authentication_id[31:0]), 256'h2000_0008);
        check("seq2_aid_w7", 256'(bus.lc_authentication_id[255:224]), 256'h2000_000F);
        check("seq2_err",    256'(bus.err), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
